// File: rtl/serial_ripple_subtractor_if.sv
// Handshake and operand/result bundle for serial_ripple_subtractor.
// The master issues start/a/b/bin and the slave returns status and results.
interface serial_ripple_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, zero, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, zero, ovf
  );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per clock with a
// single registered borrow rippling from the LSB digit to the MSB digit.
module serial_ripple_subtractor #(
  parameter int WIDTH = 4,
  parameter int DIGIT = 1
) (
  input logic                  clk,
  input logic                  rst,
  serial_ripple_subtractor_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_ripple_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t state;
  state_t next_state;
  logic   accept;
  logic   last;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] result;
  logic             borrow;
  logic             borrow_next;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   step;
  int               idx;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             zero_r;
  logic             ovf_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(NDIG - 1)) begin
          last       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // One digit of the ripple: the extra MSB of the widened difference is the borrow.
  always_comb begin
    idx         = int'(cnt) * DIGIT;
    a_dig       = a_sh[idx +: DIGIT];
    b_dig       = b_sh[idx +: DIGIT];
    step        = {1'b0, a_dig} - {1'b0, b_dig} - (DIGIT + 1)'(borrow);
    borrow_next = step[DIGIT];
    result      = work;
    result[idx +: DIGIT] = step[DIGIT-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      work   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      diff_r <= '0;
      bout_r <= 1'b0;
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        a_sh   <= bus.a;
        b_sh   <= bus.b;
        borrow <= bus.bin;
        work   <= '0;
        cnt    <= '0;
        busy_r <= 1'b1;
      end else if (state == RUN) begin
        work   <= result;
        borrow <= borrow_next;
        cnt    <= cnt + 1'b1;
        // Results are published only here so diff never shows partial digits.
        if (last) begin
          cnt    <= '0;
          diff_r <= result;
          bout_r <= borrow_next;
          zero_r <= (result == '0);
          ovf_r  <= (a_sh[WIDTH-1] != b_sh[WIDTH-1]) && (result[WIDTH-1] != a_sh[WIDTH-1]);
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;
  assign bus.zero = zero_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed and random bench for serial_ripple_subtractor with a 4-bit/1-digit
// and an 8-bit/2-digit instance; expected results flow through a scoreboard queue.
module tb_serial_ripple_subtractor;
  localparam int NDIG_T = 4;

  typedef struct packed {
    logic [7:0] diff;
    logic       bout;
    logic       zero;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst;
  bit   wide;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t last_exp;

  serial_ripple_subtractor_if #(.WIDTH(4)) bus4 ();
  serial_ripple_subtractor_if #(.WIDTH(8)) bus8 ();

  serial_ripple_subtractor #(.WIDTH(4), .DIGIT(1)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  serial_ripple_subtractor #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  logic [7:0] o_diff;
  logic       o_busy;
  logic       o_done;
  logic       o_bout;
  logic       o_zero;
  logic       o_ovf;

  assign o_diff = wide ? bus8.diff : {4'h0, bus4.diff};
  assign o_busy = wide ? bus8.busy : bus4.busy;
  assign o_done = wide ? bus8.done : bus4.done;
  assign o_bout = wide ? bus8.bout : bus4.bout;
  assign o_zero = wide ? bus8.zero : bus4.zero;
  assign o_ovf  = wide ? bus8.ovf  : bus4.ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic bo, input logic z, input logic o);
    exp_t e;
    e.diff = d;
    e.bout = bo;
    e.zero = z;
    e.ovf  = o;
    return e;
  endfunction

  // Reference: modular difference, unsigned borrow compare, sign-rule overflow.
  function automatic exp_t model(input int w, input int a, input int b, input int bi);
    exp_t e;
    int   m;
    int   r;
    m = (1 << w) - 1;
    r = (a - b - bi) & m;
    e.diff = 8'(r);
    e.bout = (a < b + bi);
    e.zero = (r == 0);
    e.ovf  = (((a >> (w - 1)) & 1) != ((b >> (w - 1)) & 1)) &&
             (((r >> (w - 1)) & 1) != ((a >> (w - 1)) & 1));
    return e;
  endfunction

  task automatic drive(input logic s, input logic [7:0] a, input logic [7:0] b, input logic bi);
    if (wide) begin
      bus8.start = s;
      bus8.a     = a;
      bus8.b     = b;
      bus8.bin   = bi;
      bus4.start = 1'b0;
    end else begin
      bus4.start = s;
      bus4.a     = a[3:0];
      bus4.b     = b[3:0];
      bus4.bin   = bi;
      bus8.start = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bi, input exp_t e);
    drive(1'b1, a, b, bi);
    sb.push_back(e);
  endtask

  // Waits for done from the start edge; operands are scrambled after capture.
  task automatic checkOutput(input string tag, input bit hold);
    int   lat;
    bit   seen;
    exp_t e;
    lat  = 0;
    seen = 0;
    @(posedge clk);
    while (!seen && lat <= 12) begin
      @(negedge clk);
      if (o_done) begin
        seen = 1;
      end else begin
        check({tag, "_busy"}, 32'(o_busy), 32'd1);
        drive(hold && (lat < NDIG_T - 1), 8'($urandom), 8'($urandom), 1'($urandom));
        @(posedge clk);
        lat++;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(NDIG_T));
    check({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_diff"}, 32'(o_diff), 32'(e.diff));
      check({tag, "_bout"}, 32'(o_bout), 32'(e.bout));
      check({tag, "_zero"}, 32'(o_zero), 32'(e.zero));
      check({tag, "_ovf"},  32'(o_ovf),  32'(e.ovf));
      check({tag, "_busy_at_done"}, 32'(o_busy), 32'd0);
      last_exp = e;
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_done_width"}, 32'(o_done), 32'd0);
    check({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_hold_diff"}, 32'(o_diff), 32'(last_exp.diff));
  endtask

  initial begin
    int   ra;
    int   rb;
    int   rbi;
    bit   stray;
    exp_t dropped;
    checks = 0;
    errors = 0;
    wide   = 0;
    rst    = 1'b1;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_diff", 32'(o_diff), 32'd0);
    check("reset_bout", 32'(o_bout), 32'd0);
    check("reset_zero", 32'(o_zero), 32'd0);
    check("reset_ovf",  32'(o_ovf),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(8'd9, 8'd3, 1'b0, mk(8'h06, 1'b0, 1'b0, 1'b1));
    checkOutput("sub_9_3", 0);
    check_idle("sub_9_3");

    applyStimulus(8'd3, 8'd9, 1'b0, mk(8'h0A, 1'b1, 1'b0, 1'b1));
    checkOutput("sub_3_9", 0);
    applyStimulus(8'd0, 8'd0, 1'b1, mk(8'h0F, 1'b1, 1'b0, 1'b0));
    checkOutput("b2b_0_0_bin", 0);
    check_idle("b2b_0_0_bin");

    applyStimulus(8'd5, 8'd5, 1'b0, mk(8'h00, 1'b0, 1'b1, 1'b0));
    checkOutput("zero_5_5", 0);
    check_idle("zero_5_5");

    applyStimulus(8'd8, 8'd1, 1'b0, mk(8'h07, 1'b0, 1'b0, 1'b1));
    checkOutput("ovf_8_1", 0);
    check_idle("ovf_8_1");

    applyStimulus(8'd2, 8'd7, 1'b1, mk(8'h0A, 1'b1, 1'b0, 1'b0));
    checkOutput("start_held", 1);
    check_idle("start_held");

    // Abort in the second RUN cycle; the pending expectation is discarded.
    applyStimulus(8'd12, 8'd3, 1'b0, mk(8'h09, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    check("abort_diff", 32'(o_diff), 32'd0);
    check("abort_bout", 32'(o_bout), 32'd0);
    check("abort_zero", 32'(o_zero), 32'd0);
    check("abort_ovf",  32'(o_ovf),  32'd0);
    dropped = sb.pop_back();
    last_exp = mk(8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_done) stray = 1;
    end
    check("abort_no_done", 32'(stray), 32'd0);
    applyStimulus(8'd12, 8'd3, 1'b0, dropped);
    checkOutput("after_abort", 0);
    check_idle("after_abort");

    wide = 1;
    @(negedge clk);
    applyStimulus(8'h10, 8'h01, 1'b1, mk(8'h0E, 1'b0, 1'b0, 1'b0));
    checkOutput("w8_10_01", 0);
    check_idle("w8_10_01");

    for (int i = 0; i < 16; i++) begin
      ra  = int'($urandom_range(255, 0));
      rb  = int'($urandom_range(255, 0));
      rbi = int'($urandom_range(1, 0));
      applyStimulus(8'(ra), 8'(rb), 1'(rbi), model(8, ra, rb, rbi));
      checkOutput($sformatf("rnd8_%0d", i), 0);
    end
    check_idle("rnd8_end");

    wide = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ra  = int'($urandom_range(15, 0));
      rb  = int'($urandom_range(15, 0));
      rbi = int'($urandom_range(1, 0));
      applyStimulus(8'(ra), 8'(rb), 1'(rbi), model(4, ra, rb, rbi));
      checkOutput($sformatf("rnd4_%0d", i), 0);
    end
    check_idle("rnd4_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
